dcd_search_ctrl: RTL and testbench
==================================

Name: dcd_search_ctrl

Overview:
- Top-level search sequencer for the per-bin SAT engine.
- Drives the decision unit (level load, decision pulses, backtrack apply), BCP start/done and conflict-analysis start/done.
- Loops decide -> propagate -> (analyse -> backtrack) until every variable is assigned (SAT) or a conflict occurs at level 0 (UNSAT).
- Sits between the engine top and the decision/BCP/analysis units; never drives two decision-unit commands in the same cycle.

Parameters:
- NUM_VARS, 8, variables per bin; width of the one-hot decided index.
- WIDTH_LVL, 16, decision-level width.
- WIDTH_CNT, 16, width of the decision and conflict statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset.
- start_i  in  1  pulse; accepted only in IDLE.
- abort_i  in  1  synchronous abort; return to IDLE, no done.
- start_lvl_i  in  WIDTH_LVL  current decision level of the loaded bin; sampled with start_i.
- load_lvl_en_o  out  1  one-cycle load strobe to the decision unit.
- load_lvl_o  out  WIDTH_LVL  level value to load; equals start_lvl + 1 (next-level convention).
- decision_pulse_o  out  1  one-cycle decide request.
- decision_done_i  in  1  decision result valid.
- index_decided_i  in  NUM_VARS  one-hot decided variable; all-zero means no free variable.
- cur_lvl_i  in  WIDTH_LVL  current level from the decision unit.
- apply_bkt_o  out  1  one-cycle backtrack strobe.
- bkt_lvl_o  out  WIDTH_LVL  next-level value for backtrack; equals ana_lvl + 1 (mod 2^WIDTH_LVL).
- bcp_start_o  out  1  one-cycle BCP start.
- bcp_done_i  in  1  BCP finished.
- conflict_i  in  1  conflict flag; valid only with bcp_done_i.
- ana_start_o  out  1  one-cycle analysis start.
- ana_done_i  in  1  analysis finished.
- ana_lvl_i  in  WIDTH_LVL  target backtrack level; valid with ana_done_i.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- sat_o  out  1  result flag; held from done until the next accepted start.
- unsat_o  out  1  result flag; held from done until the next accepted start.
- n_dec_o  out  WIDTH_CNT  decisions issued; saturating.
- n_cfl_o  out  WIDTH_CNT  conflicts seen; saturating.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE. All outputs 0: strobes, flags, counters, load_lvl_o, bkt_lvl_o. Reset mid-search discards everything immediately.
- All outputs are registered. Every strobe is exactly one cycle wide.
- States: IDLE, LOAD, BCP, W_BCP, DEC, W_DEC, ANA, W_ANA, BKT, FIN.
- IDLE:
  - start_i=1: clear sat_o, unsat_o, n_dec_o, n_cfl_o; latch start_lvl_i; go to LOAD.
  - start_i while busy is ignored.
- LOAD: load_lvl_en_o=1, load_lvl_o=start_lvl+1 -> BCP.
- BCP: bcp_start_o=1 -> W_BCP. This covers the initial propagation and the re-propagation after each decision or backtrack.
- W_BCP: wait for bcp_done_i.
  - conflict_i=0 -> DEC.
  - conflict_i=1: n_cfl+1 (saturate at all-ones). If cur_lvl_i==0 -> FIN with unsat; else -> ANA.
- DEC: decision_pulse_o=1 -> W_DEC.
- W_DEC: wait for decision_done_i.
  - index_decided_i==0 -> FIN with sat.
  - Otherwise n_dec+1 (saturating) -> BCP.
- ANA: ana_start_o=1 -> W_ANA.
- W_ANA: on ana_done_i latch ana_lvl_i -> BKT.
- BKT: apply_bkt_o=1, bkt_lvl_o=ana_lvl+1 -> BCP.
- FIN:
  - done_o=1 for one cycle; set sat_o or unsat_o; -> IDLE.
  - Exactly one of sat_o/unsat_o is set; both remain stable until the next accepted start.
- Done inputs arriving in a state that is not waiting for them are ignored.
- Latency:
  - start to load_lvl_en_o: 1 cycle.
  - Each done input to the next strobe: 1 cycle (through the intermediate command state).
- abort_i=1 in any state (checked before all transitions): -> IDLE next cycle.
  - No done_o is issued; sat_o/unsat_o stay cleared.
  - Counters hold their values.
  - Strobes deassert.
- abort_i and start_i together in IDLE: abort wins; remain in IDLE.
- load_lvl_o and bkt_lvl_o wrap modulo 2^WIDTH_LVL; an all-ones input yields 0.
- Counter saturation: at all-ones, further increments hold the value.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 -> all outputs 0, busy_o=0; start_i pulse -> load_lvl_en_o=1 next cycle.
- Normal SAT: start_lvl_i=3 -> load_lvl_o=4. BCP returns no conflict; decision_done_i with index 8'h04 twice, then 8'h00 -> done_o pulse, sat_o=1, n_dec_o=2, n_cfl_o=0.
- UNSAT: first BCP returns conflict_i=1 with cur_lvl_i=0 -> done_o, unsat_o=1, n_cfl_o=1; no ana_start_o is ever issued.
- Backtrack: conflict at cur_lvl_i=5, ana_lvl_i=2 -> ana_start_o, then apply_bkt_o with bkt_lvl_o=3, then bcp_start_o on the following cycle; decision_pulse_o and apply_bkt_o never high in the same cycle.
- Abort: abort_i asserted in W_ANA -> IDLE next cycle, done_o stays 0; a subsequent start_i is accepted and clears the counters.
- Boundary: ana_lvl_i=16'hFFFF -> bkt_lvl_o=0. Force n_cfl_o to all-ones via a long run, then one more conflict -> n_cfl_o holds at 16'hFFFF.

Source files
------------

// File: rtl/dcd_search_ctrl.sv
// Search sequencer for the per-bin SAT engine: decide -> propagate -> analyse -> backtrack
// until all variables are assigned (SAT) or a level-0 conflict is found (UNSAT).
module dcd_search_ctrl #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIDTH_LVL-1:0] start_lvl_i,
  output logic                 load_lvl_en_o,
  output logic [WIDTH_LVL-1:0] load_lvl_o,
  output logic                 decision_pulse_o,
  input  logic                 decision_done_i,
  input  logic [NUM_VARS-1:0]  index_decided_i,
  input  logic [WIDTH_LVL-1:0] cur_lvl_i,
  output logic                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic                 bcp_start_o,
  input  logic                 bcp_done_i,
  input  logic                 conflict_i,
  output logic                 ana_start_o,
  input  logic                 ana_done_i,
  input  logic [WIDTH_LVL-1:0] ana_lvl_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sat_o,
  output logic                 unsat_o,
  output logic [WIDTH_CNT-1:0] n_dec_o,
  output logic [WIDTH_CNT-1:0] n_cfl_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_BCP, S_W_BCP, S_DEC, S_W_DEC, S_ANA, S_W_ANA, S_BKT, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic load_en_nxt, dec_nxt, bkt_nxt, bcp_nxt, ana_nxt, busy_nxt, done_nxt;
  logic accept, cfl_hit, dec_hit, fin_enter;

  assign accept    = (state == S_IDLE) && start_i && !abort_i;
  assign cfl_hit   = (state == S_W_BCP) && bcp_done_i && conflict_i && !abort_i;
  assign dec_hit   = (state == S_W_DEC) && decision_done_i && (index_decided_i != '0) && !abort_i;
  assign fin_enter = (state_nxt == S_FIN);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start_i) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_BCP;
        S_BCP:   state_nxt = S_W_BCP;
        S_W_BCP: if (bcp_done_i) begin
                   if (!conflict_i)          state_nxt = S_DEC;
                   else if (cur_lvl_i == '0) state_nxt = S_FIN;
                   else                      state_nxt = S_ANA;
                 end
        S_DEC:   state_nxt = S_W_DEC;
        S_W_DEC: if (decision_done_i)
                   state_nxt = (index_decided_i == '0) ? S_FIN : S_BCP;
        S_ANA:   state_nxt = S_W_ANA;
        S_W_ANA: if (ana_done_i) state_nxt = S_BKT;
        S_BKT:   state_nxt = S_BCP;
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state and registered, so each is high exactly while in its state.
  always_comb begin
    load_en_nxt = (state_nxt == S_LOAD);
    bcp_nxt     = (state_nxt == S_BCP);
    dec_nxt     = (state_nxt == S_DEC);
    ana_nxt     = (state_nxt == S_ANA);
    bkt_nxt     = (state_nxt == S_BKT);
    done_nxt    = (state_nxt == S_FIN);
    busy_nxt    = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_lvl_en_o    <= 1'b0;
      decision_pulse_o <= 1'b0;
      apply_bkt_o      <= 1'b0;
      bcp_start_o      <= 1'b0;
      ana_start_o      <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      sat_o            <= 1'b0;
      unsat_o          <= 1'b0;
      load_lvl_o       <= '0;
      bkt_lvl_o        <= '0;
      n_dec_o          <= '0;
      n_cfl_o          <= '0;
    end else begin
      load_lvl_en_o    <= load_en_nxt;
      decision_pulse_o <= dec_nxt;
      apply_bkt_o      <= bkt_nxt;
      bcp_start_o      <= bcp_nxt;
      ana_start_o      <= ana_nxt;
      busy_o           <= busy_nxt;
      done_o           <= done_nxt;

      if (accept) begin
        sat_o      <= 1'b0;
        unsat_o    <= 1'b0;
        n_dec_o    <= '0;
        n_cfl_o    <= '0;
        load_lvl_o <= start_lvl_i + 1'b1;
      end
      if (cfl_hit && (n_cfl_o != '1)) n_cfl_o <= n_cfl_o + 1'b1;
      if (dec_hit && (n_dec_o != '1)) n_dec_o <= n_dec_o + 1'b1;
      if ((state == S_W_ANA) && ana_done_i && !abort_i) bkt_lvl_o <= ana_lvl_i + 1'b1;
      if (fin_enter) begin
        sat_o   <= (state == S_W_DEC);
        unsat_o <= (state == S_W_BCP);
      end
    end
  end

endmodule

// File: tb/tb_dcd_search_ctrl.sv
// Directed bench for dcd_search_ctrl; a second instance with 4-bit counters exercises saturation.
module tb_dcd_search_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i;
  logic [15:0] start_lvl_i, cur_lvl_i, ana_lvl_i;
  logic        decision_done_i, bcp_done_i, conflict_i, ana_done_i;
  logic [7:0]  index_decided_i;

  logic        load_lvl_en_o, decision_pulse_o, apply_bkt_o, bcp_start_o, ana_start_o;
  logic        busy_o, done_o, sat_o, unsat_o;
  logic [15:0] load_lvl_o, bkt_lvl_o, n_dec_o, n_cfl_o;

  logic        s_load_en, s_dec, s_bkt, s_bcp, s_ana, s_busy, s_done, s_sat, s_unsat;
  logic [15:0] s_load_lvl, s_bkt_lvl;
  logic [3:0]  s_n_dec, s_n_cfl;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic        overlap_seen = 1'b0;

  always #5 clk = ~clk;

  dcd_search_ctrl #(.NUM_VARS(8), .WIDTH_LVL(16), .WIDTH_CNT(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .start_lvl_i(start_lvl_i),
    .load_lvl_en_o(load_lvl_en_o), .load_lvl_o(load_lvl_o), .decision_pulse_o(decision_pulse_o),
    .decision_done_i(decision_done_i), .index_decided_i(index_decided_i), .cur_lvl_i(cur_lvl_i),
    .apply_bkt_o(apply_bkt_o), .bkt_lvl_o(bkt_lvl_o), .bcp_start_o(bcp_start_o),
    .bcp_done_i(bcp_done_i), .conflict_i(conflict_i), .ana_start_o(ana_start_o),
    .ana_done_i(ana_done_i), .ana_lvl_i(ana_lvl_i), .busy_o(busy_o), .done_o(done_o),
    .sat_o(sat_o), .unsat_o(unsat_o), .n_dec_o(n_dec_o), .n_cfl_o(n_cfl_o)
  );

  dcd_search_ctrl #(.NUM_VARS(8), .WIDTH_LVL(16), .WIDTH_CNT(4)) dut_sat (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .start_lvl_i(start_lvl_i),
    .load_lvl_en_o(s_load_en), .load_lvl_o(s_load_lvl), .decision_pulse_o(s_dec),
    .decision_done_i(decision_done_i), .index_decided_i(index_decided_i), .cur_lvl_i(cur_lvl_i),
    .apply_bkt_o(s_bkt), .bkt_lvl_o(s_bkt_lvl), .bcp_start_o(s_bcp),
    .bcp_done_i(bcp_done_i), .conflict_i(conflict_i), .ana_start_o(s_ana),
    .ana_done_i(ana_done_i), .ana_lvl_i(ana_lvl_i), .busy_o(s_busy), .done_o(s_done),
    .sat_o(s_sat), .unsat_o(s_unsat), .n_dec_o(s_n_dec), .n_cfl_o(s_n_cfl)
  );

  always @(posedge clk) if (decision_pulse_o && apply_bkt_o) overlap_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after entering W_BCP; the edge consumes the BCP result.
  task automatic bcp_result(input logic cfl, input logic [15:0] lvl);
    bcp_done_i = 1'b1; conflict_i = cfl; cur_lvl_i = lvl;
    tick();
    bcp_done_i = 1'b0; conflict_i = 1'b0;
  endtask

  task automatic dec_result(input logic [7:0] idx);
    decision_done_i = 1'b1; index_decided_i = idx;
    tick();
    decision_done_i = 1'b0; index_decided_i = '0;
  endtask

  task automatic start_search(input logic [15:0] lvl);
    start_i = 1'b1; start_lvl_i = lvl;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; start_lvl_i = '0; cur_lvl_i = '0; ana_lvl_i = '0;
    decision_done_i = 1'b0; bcp_done_i = 1'b0; conflict_i = 1'b0; ana_done_i = 1'b0;
    index_decided_i = '0;
    tick(); tick();
    check("rst_busy", busy_o, 0);
    check("rst_strobes", {load_lvl_en_o, decision_pulse_o, apply_bkt_o, bcp_start_o, ana_start_o, done_o}, 0);
    check("rst_flags", {sat_o, unsat_o}, 0);
    check("rst_lvls", {load_lvl_o, bkt_lvl_o}, 0);
    check("rst_cnts", {n_dec_o, n_cfl_o}, 0);
    rst = 1'b1;
    tick();
    check("idle_busy", busy_o, 0);

    // SAT run: two decisions then no free variable
    start_search(16'd3);
    check("sat_load_en", load_lvl_en_o, 1);
    check("sat_load_lvl", load_lvl_o, 16'd4);
    check("sat_busy", busy_o, 1);
    tick();
    check("sat_bcp_start", {bcp_start_o, load_lvl_en_o}, 2'b10);
    tick();
    check("sat_wbcp", bcp_start_o, 0);
    bcp_result(1'b0, 16'd4);
    check("sat_dec_pulse", decision_pulse_o, 1);
    tick();
    bcp_done_i = 1'b1;                       // stray done while waiting for a decision
    tick();
    bcp_done_i = 1'b0;
    check("ignored_done", {decision_pulse_o, bcp_start_o, busy_o}, 3'b001);
    dec_result(8'h04);
    check("sat_rebcp", bcp_start_o, 1);
    check("sat_ndec1", n_dec_o, 1);
    tick();
    bcp_result(1'b0, 16'd5);
    tick();
    dec_result(8'h04);
    check("sat_ndec2", n_dec_o, 2);
    tick();
    bcp_result(1'b0, 16'd6);
    tick();
    dec_result(8'h00);
    check("sat_done", done_o, 1);
    check("sat_flags", {sat_o, unsat_o}, 2'b10);
    check("sat_cnts", {n_dec_o, n_cfl_o}, {16'd2, 16'd0});
    tick();
    check("sat_after", {done_o, busy_o, sat_o}, 3'b001);

    // UNSAT run: level-0 conflict on first propagation
    start_search(16'd0);
    check("unsat_clear", {sat_o, unsat_o, n_dec_o}, 0);
    tick(); tick();
    bcp_result(1'b1, 16'd0);
    check("unsat_done", done_o, 1);
    check("unsat_flags", {sat_o, unsat_o}, 2'b01);
    check("unsat_ncfl", n_cfl_o, 1);
    check("unsat_no_ana", ana_start_o, 0);
    tick();
    check("unsat_after", {done_o, busy_o, unsat_o, ana_start_o}, 4'b0010);

    // Backtrack, level wrap, saturation, abort
    start_search(16'd5);
    check("bt_clear", {n_cfl_o, unsat_o}, 0);
    tick(); tick();
    bcp_result(1'b0, 16'd6);
    tick();
    dec_result(8'h01);
    tick();
    bcp_result(1'b1, 16'd5);
    check("bt_ana_start", ana_start_o, 1);
    check("bt_ncfl1", n_cfl_o, 1);
    tick();
    check("bt_wana", ana_start_o, 0);
    ana_done_i = 1'b1; ana_lvl_i = 16'd2;
    tick();
    ana_done_i = 1'b0;
    check("bt_apply", {apply_bkt_o, decision_pulse_o}, 2'b10);
    check("bt_lvl", bkt_lvl_o, 16'd3);
    tick();
    check("bt_rebcp", {bcp_start_o, apply_bkt_o}, 2'b10);
    tick();
    bcp_result(1'b1, 16'd3);
    tick();
    ana_done_i = 1'b1; ana_lvl_i = 16'hFFFF;
    tick();
    ana_done_i = 1'b0;
    check("bt_lvl_wrap", bkt_lvl_o, 16'd0);
    tick(); tick();
    for (int i = 0; i < 18; i++) begin
      bcp_result(1'b1, 16'd7);
      tick();
      ana_done_i = 1'b1; ana_lvl_i = 16'd1;
      tick();
      ana_done_i = 1'b0;
      tick(); tick();
    end
    check("sat_cnt_hold", s_n_cfl, 4'hF);
    check("main_ncfl20", n_cfl_o, 20);
    bcp_result(1'b1, 16'd7);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_idle", {busy_o, done_o, ana_start_o, bcp_start_o}, 0);
    check("abort_flags", {sat_o, unsat_o}, 0);
    check("abort_cnts", {n_dec_o, n_cfl_o}, {16'd1, 16'd21});
    check("abort_sat_cnt", s_n_cfl, 4'hF);
    tick();
    check("abort_no_done", done_o, 0);

    start_i = 1'b1; abort_i = 1'b1; start_lvl_i = 16'd9;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_wins", {busy_o, load_lvl_en_o}, 0);
    start_search(16'hFFFF);
    check("restart_load", {load_lvl_en_o, busy_o}, 2'b11);
    check("restart_wrap", load_lvl_o, 16'd0);
    check("restart_cnts", {n_dec_o, n_cfl_o}, 0);

    // Reset mid-search
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst", {busy_o, bcp_start_o, load_lvl_o, n_cfl_o}, 0);
    check("no_overlap", overlap_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
